mult_job_sequencer: RTL and testbench

//  Upstream feeder for the shift-add sequential multiplier. Buffers operand pairs from a

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_job_sequencer_if.sv | 39 +++
 rtl/mult_op_fifo.sv | 57 +++++
 rtl/mult_job_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mult_job_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiply job sequencer.
// Contents: FSM state encoding (one-hot), default operand width, product width helper.
package mult_pkg;

  localparam int unsigned DefaultWidth     = 16;
  localparam int unsigned DefaultProdWidth = 2 * DefaultWidth;

  // Product of two WIDTH-bit operands is 2*WIDTH bits wide.
  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StStart   = 5'b00010,
    StWait    = 5'b00100,
    StRelease = 5'b01000,
    StDrain   = 5'b10000
  } state_e;

endpackage

// File: rtl/mult_job_sequencer_if.sv
// Signal bundle for the multiply job sequencer.
// Groups: operand input stream (in_*), multiplier core handshake (mult_*),
// result output stream (out_*), and the busy status flag.
// Modport master: the sequencer's view. Modport slave: the surrounding environment.
interface mult_job_sequencer_if #(
  parameter int unsigned WIDTH = mult_pkg::DefaultWidth
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_mplier;
  logic [WIDTH-1:0]   in_mcand;

  logic               mult_st;
  logic [WIDTH-1:0]   mult_mplier;
  logic [WIDTH-1:0]   mult_mcand;
  logic               mult_done;
  logic [2*WIDTH-1:0] mult_product;

  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic               out_timeout;

  logic               busy;

  modport master (
    input  in_valid, in_mplier, in_mcand, mult_done, mult_product, out_ready,
    output in_ready, mult_st, mult_mplier, mult_mcand, out_valid, out_product, out_timeout,
           busy
  );

  modport slave (
    output in_valid, in_mplier, in_mcand, mult_done, mult_product, out_ready,
    input  in_ready, mult_st, mult_mplier, mult_mcand, out_valid, out_product, out_timeout,
           busy
  );

endinterface

// File: rtl/mult_op_fifo.sv
// Synchronous FIFO for operand pairs.
// Ports: clk, rst (sync, active-high), wr_en/wr_data (push), rd_en (pop),
// rd_data (head entry, combinational), full, empty.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module mult_op_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/mult_job_sequencer.sv
// Feeds a shift-add sequential multiplier one job at a time.
// Operand pairs are buffered in mult_op_fifo; the FIFO head drives the core operands and is
// popped only after the product is captured, so operands stay stable for the whole job.
// Ports: clk, rst (sync, active-high), bus (mult_job_sequencer_if.master):
//   in_*   operand valid/ready input      mult_* St/Done core handshake
//   out_*  product valid/ready output     busy   FSM active or FIFO non-empty
// Optional feature: define MULT_TIMEOUT_EN to abort a job after TIMEOUT cycles without Done;
// the aborted job returns product 0 with out_timeout=1. Undefined: out_timeout is tied to 0.
module mult_job_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic                  clk,
  input logic                  rst,
  mult_job_sequencer_if.master bus
);

  localparam int unsigned ProdW = prod_width(WIDTH);

  state_e           state_q, state_d;
  logic             mult_st_q;
  logic             out_valid_q;
  logic [ProdW-1:0] out_product_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [ProdW-1:0] head;
  logic             push;
  logic             pop;
  logic             capture;
  logic             capture_timeout;
  logic             slot_free;

  assign push = bus.in_valid & ~fifo_full;

  mult_op_fifo #(
    .WIDTH (ProdW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({bus.in_mplier, bus.in_mcand}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Result slot can take a product if empty or being drained this very cycle.
  assign slot_free = ~out_valid_q | bus.out_ready;

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            tmo_hit;
  logic            out_timeout_q;

  // Counts cycles with St high (0 in the START cycle); saturates once expired.
  assign tmo_hit = (tmo_cnt_q >= CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StStart || state_q == StWait) begin
      if (!tmo_hit) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_timeout_q <= 1'b0;
    end else if (capture) begin
      out_timeout_q <= capture_timeout;
    end else if (out_valid_q && bus.out_ready) begin
      out_timeout_q <= 1'b0;
    end
  end

  assign bus.out_timeout = out_timeout_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout  = TIMEOUT;
  assign bus.out_timeout = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    capture         = 1'b0;
    capture_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Done still high means the core has not returned to idle yet.
        if (!fifo_empty && !bus.mult_done) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        // With the slot occupied we stay here; the core keeps Done asserted.
        if (bus.mult_done && slot_free) begin
          capture = 1'b1;
          state_d = StRelease;
        end
`ifdef MULT_TIMEOUT_EN
        else if (!bus.mult_done && tmo_hit && slot_free) begin
          capture         = 1'b1;
          capture_timeout = 1'b1;
          pop             = 1'b1;
          state_d         = StDrain;
        end
`endif
      end
      StRelease: begin
        pop     = 1'b1;
        state_d = StDrain;
      end
      StDrain: begin
        if (!bus.mult_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      mult_st_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      state_q   <= state_d;
      mult_st_q <= (state_d == StStart) || (state_d == StWait);
      // A capture wins over a same-cycle output transfer.
      if (capture) begin
        out_valid_q   <= 1'b1;
        out_product_q <= capture_timeout ? '0 : bus.mult_product;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = ~fifo_full;
  assign bus.mult_st     = mult_st_q;
  assign bus.mult_mplier = head[ProdW-1:WIDTH];
  assign bus.mult_mcand  = head[WIDTH-1:0];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign bus.busy        = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Self-checking bench for mult_job_sequencer with a behavioural multiplier core
// (Done rises 20 cycles after St and holds while St=1) and a queue-based scoreboard.
module tb_mult_job_sequencer;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  typedef struct packed {
    logic [31:0] prod;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
  } vec_t;

  logic clk;
  logic rst;

  int    checks = 0;
  int    errors = 0;
  int    n_out = 0;
  int    acc_total = 0;
  int    core_cnt;
  bit    core_dead;
  bit    hold_ready;
  bit    last_in_ready;
  exp_t  exp_q[$];
  pair_t src_q[$];
  vec_t  vecs[8];

  mult_job_sequencer_if #(.WIDTH(16)) bus ();

  mult_job_sequencer #(
    .WIDTH      (16),
    .FIFO_DEPTH (4),
    .TIMEOUT    (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  // Behavioural core: Done 20 cycles after St rises, held while St stays high.
  always @(posedge clk) begin
    if (rst || !bus.mult_st || core_dead) begin
      core_cnt          <= 0;
      bus.mult_done     <= 1'b0;
      bus.mult_product  <= 32'h0;
    end else if (core_cnt >= 19) begin
      bus.mult_done    <= 1'b1;
      bus.mult_product <= 32'(int'($signed(bus.mult_mplier)) * int'($signed(bus.mult_mcand)));
    end else begin
      core_cnt <= core_cnt + 1;
    end
  end

  // Scoreboard: expectations enter at input transfer, leave at output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e.prod = core_dead ? 32'h0 : ref_product(bus.in_mplier, bus.in_mcand);
        e.tmo  = core_dead;
        exp_q.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_product", 64'(bus.out_product), 64'(e.prod));
          check("sb_timeout", 64'(bus.out_timeout), 64'(e.tmo));
        end
      end
    end
  end

  // One cycle per iteration: rmode 0 = out_ready from hold_ready, 1 = toggle, 2 = random.
  task automatic run_cycles(input int n, input int rmode, input bit rvalid);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (src_q.size() != 0 && (!rvalid || $urandom_range(0, 1) == 1)) begin
        bus.in_valid  = 1'b1;
        bus.in_mplier = src_q[0].a;
        bus.in_mcand  = src_q[0].b;
      end else begin
        bus.in_valid = 1'b0;
      end
      case (rmode)
        0:       bus.out_ready = hold_ready;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      last_in_ready = bus.in_ready;
      if (bus.in_valid && bus.in_ready) begin
        src_q.delete(0);
        acc_total++;
      end
    end
  endtask

  task automatic quiet();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    src_q.push_back(p);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int n0;
    n0 = n_out;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mplier = v.a;
    bus.in_mcand  = v.b;
    @(negedge clk);
    check("vec_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.mult_st && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("vec_st_latency", 64'(lat), 64'd2);
    check("vec_mplier_held", 64'(bus.mult_mplier), 64'(v.a));
    check("vec_mcand_held", 64'(bus.mult_mcand), 64'(v.b));
    lat = 0;
    while (!bus.mult_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("vec_done_seen", 64'(bus.mult_done), 64'd1);
    @(negedge clk);
    check("vec_out_valid", 64'(bus.out_valid), 64'd1);
    check("vec_product", 64'(bus.out_product), 64'(v.prod));
    check("vec_timeout", 64'(bus.out_timeout), 64'd0);
    lat = 0;
    while ((bus.busy || bus.out_valid) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (5) @(negedge clk);
    check("vec_one_transfer", 64'(n_out - n0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int a0;
    int lat;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFD, 16'h0005, 32'hFFFFFFF1};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[4] = '{16'h8000, 16'h0001, 32'hFFFF8000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[6] = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[7] = '{16'h8000, 16'h7FFF, 32'hC0008000};

    rst           = 1'b1;
    core_dead     = 1'b0;
    hold_ready    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mplier = 16'h0;
    bus.in_mcand  = 16'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mult_st", 64'(bus.mult_st), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_product", 64'(bus.out_product), 64'd0);
    check("rst_out_timeout", 64'(bus.out_timeout), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // Table-driven single jobs.
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Back-pressure: five pairs with the consumer stalled.
    hold_ready = 1'b0;
    n0 = n_out;
    a0 = acc_total;
    for (int k = 0; k < 5; k++) begin
      push_pair(16'(k + 1), 16'(16'h0100 + k));
    end
    for (int i = 0; i < 50 && acc_total - a0 < 4; i++) run_cycles(1, 0, 1'b0);
    run_cycles(1, 0, 1'b0);
    check("bp_full_in_ready", 64'(last_in_ready), 64'd0);
    for (int i = 0; i < 100 && acc_total - a0 < 5; i++) run_cycles(1, 0, 1'b0);
    check("bp_all_accepted", 64'(acc_total - a0), 64'd5);
    run_cycles(40, 0, 1'b0);
    check("bp_st_held", 64'(bus.mult_st), 64'd1);
    check("bp_done_held", 64'(bus.mult_done), 64'd1);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_no_transfer", 64'(n_out - n0), 64'd0);
    hold_ready = 1'b1;
    for (int i = 0; i < 400 && n_out - n0 < 5; i++) run_cycles(1, 0, 1'b0);
    run_cycles(30, 0, 1'b0);
    check("bp_drained", 64'(n_out - n0), 64'd5);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    check("bp_idle", 64'(bus.busy), 64'd0);
    quiet();

    // Reset while a job is in WAIT with a held result and queued pairs.
    hold_ready = 1'b0;
    n0 = n_out;
    for (int k = 0; k < 3; k++) push_pair(16'(k + 20), 16'h0011);
    for (int i = 0; i < 200 && !bus.out_valid; i++) run_cycles(1, 0, 1'b0);
    for (int i = 0; i < 50 && !bus.mult_st; i++) run_cycles(1, 0, 1'b0);
    run_cycles(5, 0, 1'b0);
    check("mid_st_before_rst", 64'(bus.mult_st), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    src_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_mult_st", 64'(bus.mult_st), 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_product", 64'(bus.out_product), 64'd0);
    hold_ready = 1'b1;
    run_cycles(60, 0, 1'b0);
    check("mid_rst_no_output", 64'(n_out - n0), 64'd0);
    check("mid_rst_still_idle", 64'(bus.busy), 64'd0);

    // out_ready toggling every cycle.
    n0 = n_out;
    push_pair(16'h0042, 16'hFF00);
    push_pair(16'h1111, 16'h0003);
    push_pair(16'hABCD, 16'h8001);
    for (int i = 0; i < 300 && n_out - n0 < 3; i++) run_cycles(1, 1, 1'b0);
    run_cycles(30, 1, 1'b0);
    check("toggle_count", 64'(n_out - n0), 64'd3);
    check("toggle_sb_empty", 64'(exp_q.size()), 64'd0);
    quiet();

    // Randomized traffic against the scoreboard.
    n0 = n_out;
    for (int k = 0; k < 30; k++) push_pair(16'($urandom), 16'($urandom));
    for (int i = 0; i < 4000 && n_out - n0 < 30; i++) run_cycles(1, 2, 1'b1);
    hold_ready = 1'b1;
    run_cycles(30, 0, 1'b0);
    check("rand_count", 64'(n_out - n0), 64'd30);
    check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
    check("rand_idle", 64'(bus.busy), 64'd0);
    quiet();

`ifdef MULT_TIMEOUT_EN
    // Core never answers: job aborts after TIMEOUT cycles, next job runs normally.
    core_dead  = 1'b1;
    hold_ready = 1'b0;
    n0 = n_out;
    push_pair(16'h0007, 16'h0009);
    for (int i = 0; i < 20 && !bus.mult_st; i++) run_cycles(1, 0, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      run_cycles(1, 0, 1'b0);
      lat++;
    end
    check("tmo_latency", 64'(lat), 64'd64);
    check("tmo_flag", 64'(bus.out_timeout), 64'd1);
    check("tmo_product", 64'(bus.out_product), 64'd0);
    check("tmo_st_dropped", 64'(bus.mult_st), 64'd0);
    core_dead  = 1'b0;
    hold_ready = 1'b1;
    push_pair(16'h0007, 16'h0009);
    for (int i = 0; i < 200 && n_out - n0 < 2; i++) run_cycles(1, 0, 1'b0);
    run_cycles(30, 0, 1'b0);
    check("tmo_next_job", 64'(n_out - n0), 64'd2);
    check("tmo_sb_empty", 64'(exp_q.size()), 64'd0);
    check("tmo_flag_cleared", 64'(bus.out_timeout), 64'd0);
    quiet();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
